// File: rtl/btb_update_queue_if.sv
// Bundle interface for btb_update_queue: c1_* update input, BTB write port, overflow flag.
// Optional BTB_UPDATE_PERF_EN adds the drop/enqueue counters to the bundle.
interface btb_update_queue_if;
  logic        flush_i;
  logic        upd_valid_i;
  logic [31:0] c1_btb_vpc_i;
  logic [31:0] c1_btb_target_i;
  logic [1:0]  c1_cntr_pred_i;
  logic        c1_bnch_tkn_i;
  logic [1:0]  c1_bnch_type_i;
  logic        c1_bnch_present_i;
  logic        wb_btb_way_i;
  logic        wb_btb_bm_mod_i;
  logic        btb_wr_valid_o;
  logic        btb_wr_ready_i;
  logic [31:0] btb_wr_vpc_o;
  logic [31:0] btb_wr_target_o;
  logic [1:0]  btb_wr_cntr_o;
  logic [1:0]  btb_wr_type_o;
  logic        btb_wr_way_o;
  logic        btb_wr_alloc_o;
  logic        ovf_o;
`ifdef BTB_UPDATE_PERF_EN
  logic [15:0] drop_cnt_o;
  logic [15:0] upd_cnt_o;

  modport slave (
    input  flush_i, upd_valid_i, c1_btb_vpc_i, c1_btb_target_i, c1_cntr_pred_i,
           c1_bnch_tkn_i, c1_bnch_type_i, c1_bnch_present_i, wb_btb_way_i,
           wb_btb_bm_mod_i, btb_wr_ready_i,
    output btb_wr_valid_o, btb_wr_vpc_o, btb_wr_target_o, btb_wr_cntr_o, btb_wr_type_o,
           btb_wr_way_o, btb_wr_alloc_o, ovf_o, drop_cnt_o, upd_cnt_o
  );

  modport master (
    output flush_i, upd_valid_i, c1_btb_vpc_i, c1_btb_target_i, c1_cntr_pred_i,
           c1_bnch_tkn_i, c1_bnch_type_i, c1_bnch_present_i, wb_btb_way_i,
           wb_btb_bm_mod_i, btb_wr_ready_i,
    input  btb_wr_valid_o, btb_wr_vpc_o, btb_wr_target_o, btb_wr_cntr_o, btb_wr_type_o,
           btb_wr_way_o, btb_wr_alloc_o, ovf_o, drop_cnt_o, upd_cnt_o
  );
`else
  modport slave (
    input  flush_i, upd_valid_i, c1_btb_vpc_i, c1_btb_target_i, c1_cntr_pred_i,
           c1_bnch_tkn_i, c1_bnch_type_i, c1_bnch_present_i, wb_btb_way_i,
           wb_btb_bm_mod_i, btb_wr_ready_i,
    output btb_wr_valid_o, btb_wr_vpc_o, btb_wr_target_o, btb_wr_cntr_o, btb_wr_type_o,
           btb_wr_way_o, btb_wr_alloc_o, ovf_o
  );

  modport master (
    output flush_i, upd_valid_i, c1_btb_vpc_i, c1_btb_target_i, c1_cntr_pred_i,
           c1_bnch_tkn_i, c1_bnch_type_i, c1_bnch_present_i, wb_btb_way_i,
           wb_btb_bm_mod_i, btb_wr_ready_i,
    input  btb_wr_valid_o, btb_wr_vpc_o, btb_wr_target_o, btb_wr_cntr_o, btb_wr_type_o,
           btb_wr_way_o, btb_wr_alloc_o, ovf_o
  );
`endif
endinterface

// File: rtl/btb_update_queue.sv
// BTB update queue: filters resolved-branch updates, computes the new bimodal counter
// and buffers them in a FIFO that drains into the BTB write port.
// Optional feature macro: BTB_UPDATE_PERF_EN (saturating drop/enqueue counters).
module btb_update_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic            cpu_clock_i,
  input logic            cpu_reset_i,
  btb_update_queue_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] vpc;
    logic [31:0] target;
    logic [1:0]  cntr;
    logic [1:0]  btype;
    logic        way;
    logic        alloc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          ovf_q;
  logic          empty, full, qual, pop, push, drop;
  logic [1:0]    new_cntr;
  entry_t        new_entry;
  entry_t        head;

  // Occupancy flags from wrap-bit pointers; qualification and push/pop/drop decisions.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    qual  = bus.upd_valid_i && !bus.flush_i &&
            ((bus.c1_bnch_present_i && bus.wb_btb_bm_mod_i) ||
             (!bus.c1_bnch_present_i && bus.c1_bnch_tkn_i));
    pop   = !empty && bus.btb_wr_ready_i;
    // A pop in the same cycle frees the slot the new entry needs.
    push  = qual && (!full || pop);
    drop  = qual && full && !pop;
  end

  // New bimodal counter value and the entry to be written at the tail.
  always_comb begin
    new_cntr = 2'b11;
    if (bus.c1_bnch_type_i == 2'b00) begin
      if (!bus.c1_bnch_present_i) begin
        new_cntr = 2'b10;
      end else if (bus.c1_bnch_tkn_i) begin
        new_cntr = (bus.c1_cntr_pred_i == 2'b11) ? 2'b11 : bus.c1_cntr_pred_i + 2'b01;
      end else begin
        new_cntr = (bus.c1_cntr_pred_i == 2'b00) ? 2'b00 : bus.c1_cntr_pred_i - 2'b01;
      end
    end
    new_entry.vpc    = bus.c1_btb_vpc_i;
    new_entry.target = bus.c1_btb_target_i;
    new_entry.cntr   = new_cntr;
    new_entry.btype  = bus.c1_bnch_type_i;
    new_entry.way    = bus.wb_btb_way_i;
    new_entry.alloc  = !bus.c1_bnch_present_i;
  end

  // Queue storage, pointers and the registered overflow pulse.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= new_entry;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
      ovf_q <= drop;
    end
  end

  // Write port is driven directly from the head slot.
  always_comb begin
    head                = mem_q[rd_ptr_q[AW-1:0]];
    bus.btb_wr_valid_o  = !empty;
    bus.btb_wr_vpc_o    = head.vpc;
    bus.btb_wr_target_o = head.target;
    bus.btb_wr_cntr_o   = head.cntr;
    bus.btb_wr_type_o   = head.btype;
    bus.btb_wr_way_o    = head.way;
    bus.btb_wr_alloc_o  = head.alloc;
    bus.ovf_o           = ovf_q;
  end

`ifdef BTB_UPDATE_PERF_EN
  logic [15:0] drop_cnt_q, upd_cnt_q;

  // Saturating counters of dropped and enqueued updates.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      drop_cnt_q <= '0;
      upd_cnt_q  <= '0;
    end else begin
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (push && upd_cnt_q != 16'hFFFF)  upd_cnt_q  <= upd_cnt_q + 16'd1;
    end
  end

  assign bus.drop_cnt_o = drop_cnt_q;
  assign bus.upd_cnt_o  = upd_cnt_q;
`endif
endmodule

// File: tb/tb_btb_update_queue.sv
// Self-checking bench for btb_update_queue: directed vector table, hand-written
// full/overflow/reset sequences, and a randomized run against a queue-based model.
module tb_btb_update_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btb_update_queue_if bus ();

  btb_update_queue #(.DEPTH(DEPTH)) dut (
    .cpu_clock_i (clk),
    .cpu_reset_i (rst),
    .bus         (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic fl, input logic [31:0] vpc,
                       input logic [31:0] tgt, input logic [1:0] pred, input logic tkn,
                       input logic [1:0] typ, input logic pres, input logic way,
                       input logic bm);
    bus.upd_valid_i       = v;
    bus.flush_i           = fl;
    bus.c1_btb_vpc_i      = vpc;
    bus.c1_btb_target_i   = tgt;
    bus.c1_cntr_pred_i    = pred;
    bus.c1_bnch_tkn_i     = tkn;
    bus.c1_bnch_type_i    = typ;
    bus.c1_bnch_present_i = pres;
    bus.wb_btb_way_i      = way;
    bus.wb_btb_bm_mod_i   = bm;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    bus.btb_wr_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed single-update vectors, each applied to an empty queue with ready=1.
  typedef struct {
    logic       flush, pres, bm, tkn;
    logic [1:0] typ, pred;
    logic       enq;
    logic [1:0] cntr;
  } tv_t;

  tv_t tv [11];

  // Reference model of queued entries.
  typedef struct {
    logic [31:0] vpc, target;
    logic [1:0]  cntr, typ;
    logic        way, alloc;
  } ent_t;

  ent_t mq [$];

  function automatic logic [1:0] ref_cntr(input int typ, input int pres, input int tkn,
                                          input int pred);
    int r;
    if (typ != 0)       r = 3;
    else if (pres == 0) r = 2;
    else if (tkn != 0)  r = (pred + 1 > 3) ? 3 : pred + 1;
    else                r = (pred - 1 < 0) ? 0 : pred - 1;
    return 2'(r);
  endfunction

  int ovf_count;

  initial begin
    idle();
    bus.btb_wr_ready_i = 1'b0;
    tv[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd3, 1'b1, 2'd3};
    tv[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 2'd2};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0};
    tv[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 2'd0};
    tv[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 1'b1, 2'd2};
    tv[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 1'b1, 2'd1};
    tv[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 2'd0};
    tv[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 1'b1, 2'd3};
    tv[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 2'd0, 1'b1, 2'd3};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0};
    tv[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 2'd1, 1'b1, 2'd3};

    // T1: reset then idle
    do_reset();
    repeat (5) @(negedge clk);
    chk("rst_valid", 64'(bus.btb_wr_valid_o), 64'd0);
    chk("rst_ovf", 64'(bus.ovf_o), 64'd0);
    chk("rst_vpc", 64'(bus.btb_wr_vpc_o), 64'd0);
    chk("rst_target", 64'(bus.btb_wr_target_o), 64'd0);
    chk("rst_fields", 64'({bus.btb_wr_cntr_o, bus.btb_wr_type_o, bus.btb_wr_way_o,
                           bus.btb_wr_alloc_o}), 64'd0);

    // T2/T3/T6: vector table
    bus.btb_wr_ready_i = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(1'b1, tv[i].flush, 32'h1000 + 32'(i), 32'h2000 + 32'(i), tv[i].pred, tv[i].tkn,
            tv[i].typ, tv[i].pres, 1'(i), tv[i].bm);
      @(posedge clk);
      @(negedge clk);
      idle();
      chk($sformatf("tv%0d_valid", i), 64'(bus.btb_wr_valid_o), 64'(tv[i].enq));
      if (tv[i].enq) begin
        chk($sformatf("tv%0d_vpc", i), 64'(bus.btb_wr_vpc_o), 64'h1000 + 64'(i));
        chk($sformatf("tv%0d_target", i), 64'(bus.btb_wr_target_o), 64'h2000 + 64'(i));
        chk($sformatf("tv%0d_cntr", i), 64'(bus.btb_wr_cntr_o), 64'(tv[i].cntr));
        chk($sformatf("tv%0d_type", i), 64'(bus.btb_wr_type_o), 64'(tv[i].typ));
        chk($sformatf("tv%0d_way", i), 64'(bus.btb_wr_way_o), 64'(i % 2));
        chk($sformatf("tv%0d_alloc", i), 64'(bus.btb_wr_alloc_o), 64'(!tv[i].pres));
      end
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tv%0d_drained", i), 64'(bus.btb_wr_valid_o), 64'd0);
    end

    // T4: overfill with ready=0, exactly one ovf pulse, FIFO drain
    do_reset();
    ovf_count = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h100 + 32'(i), 32'h900 + 32'(i), 2'd0, 1'b1, 2'd0, 1'b0, 1'b0,
            1'b0);
      @(posedge clk);
      @(negedge clk);
      if (bus.ovf_o) ovf_count++;
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ovf_o) ovf_count++;
    end
    chk("t4_ovf_pulses", 64'(ovf_count), 64'd1);
    bus.btb_wr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_pop%0d_valid", i), 64'(bus.btb_wr_valid_o), 64'd1);
      chk($sformatf("t4_pop%0d_vpc", i), 64'(bus.btb_wr_vpc_o), 64'h100 + 64'(i));
      @(posedge clk);
      @(negedge clk);
    end
    chk("t4_empty", 64'(bus.btb_wr_valid_o), 64'd0);

    // T5: full, pop and push in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h200 + 32'(i), 32'h0, 2'd2, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    drive(1'b1, 1'b0, 32'h204, 32'h0, 2'd2, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
    bus.btb_wr_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle();
    bus.btb_wr_ready_i = 1'b0;
    chk("t5_no_ovf", 64'(bus.ovf_o), 64'd0);
    bus.btb_wr_ready_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("t5_pop%0d_valid", i), 64'(bus.btb_wr_valid_o), 64'd1);
      chk($sformatf("t5_pop%0d_vpc", i), 64'(bus.btb_wr_vpc_o), 64'h200 + 64'(i));
      @(posedge clk);
      @(negedge clk);
    end
    chk("t5_empty", 64'(bus.btb_wr_valid_o), 64'd0);

    // Reset mid-drain
    bus.btb_wr_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 32'h300 + 32'(i), 32'h0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    idle();
    bus.btb_wr_ready_i = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_valid", 64'(bus.btb_wr_valid_o), 64'd0);
    chk("rstmid_vpc", 64'(bus.btb_wr_vpc_o), 64'd0);
    rst = 1'b0;

    // Randomized run against the reference model
    do_reset();
    mq.delete();
    begin
      logic exp_ovf;
      exp_ovf = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        bit v, fl, pres, tkn, bm, way, rdy, q, pop, was_full;
        int typ, pred;
        logic [31:0] vpc, tgt;
        ent_t e;
        chk("rnd_valid", 64'(bus.btb_wr_valid_o), 64'(mq.size() != 0));
        chk("rnd_ovf", 64'(bus.ovf_o), 64'(exp_ovf));
        if (mq.size() != 0) begin
          chk("rnd_vpc", 64'(bus.btb_wr_vpc_o), 64'(mq[0].vpc));
          chk("rnd_target", 64'(bus.btb_wr_target_o), 64'(mq[0].target));
          chk("rnd_fields", 64'({bus.btb_wr_cntr_o, bus.btb_wr_type_o, bus.btb_wr_way_o,
                                 bus.btb_wr_alloc_o}),
              64'({mq[0].cntr, mq[0].typ, mq[0].way, mq[0].alloc}));
        end
        v    = ($urandom % 4) != 0;
        fl   = ($urandom % 8) == 0;
        pres = 1'($urandom);
        tkn  = 1'($urandom);
        bm   = 1'($urandom);
        way  = 1'($urandom);
        typ  = int'($urandom % 4);
        pred = int'($urandom % 4);
        vpc  = $urandom;
        tgt  = $urandom;
        rdy  = ($urandom % 3) == 0;
        drive(v, fl, vpc, tgt, 2'(pred), tkn, 2'(typ), pres, way, bm);
        bus.btb_wr_ready_i = rdy;
        q        = v && !fl && ((pres && bm) || (!pres && tkn));
        was_full = (mq.size() == DEPTH);
        pop      = (mq.size() != 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (q && mq.size() < DEPTH) begin
          e.vpc    = vpc;
          e.target = tgt;
          e.cntr   = ref_cntr(typ, int'(pres), int'(tkn), pred);
          e.typ    = 2'(typ);
          e.way    = way;
          e.alloc  = !pres;
          mq.push_back(e);
        end
        exp_ovf = q && was_full && !pop;
        @(posedge clk);
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
